// File: rtl/key_pio_debounced_pkg.sv
// key_pio_pkg: register addresses and reset values for the debounced key PIO.
package key_pio_pkg;
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RISE = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAP  = 3'd3;
  localparam logic [2:0] ADDR_FALL = 3'd4;
  localparam logic [2:0] ADDR_RAW  = 3'd5;
  localparam logic [2:0] ADDR_LONG = 3'd6;
  localparam logic [31:0] RISE_EN_RST  = 32'h0000_0000;
  localparam logic [31:0] FALL_EN_RST  = 32'hFFFF_FFFF;
  localparam logic [31:0] IRQ_MASK_RST = 32'h0000_0000;
  localparam logic [31:0] EDGE_CAP_RST = 32'h0000_0000;
endpackage

// File: rtl/key_pio_debounced_if.sv
// key_pio_debounced_if: Avalon-MM slave bus and interrupt of the key PIO.
interface key_pio_debounced_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master (output chipselect, address, write_n, writedata, input readdata, irq);
  modport slave (input chipselect, address, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/key_pio_debounced_debounce.sv
// key_debounce: one key channel -- synchroniser, debounce counter, debounced level, edge pulses.
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic sync_o,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic nxt, accept;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  assign sync_o = sync_q[SYNC_STAGES-1];
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // Last synchroniser stage doubles as the debounced flop; edge is seen one stage early.
    assign nxt     = sync_q[SYNC_STAGES-2];
    assign accept  = sync_q[SYNC_STAGES-2] ^ sync_q[SYNC_STAGES-1];
    assign level_o = sync_q[SYNC_STAGES-1];
  end else begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic level_q, mismatch;
    assign nxt      = sync_q[SYNC_STAGES-1];
    assign mismatch = nxt ^ level_q;
    assign accept   = mismatch && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt_q   <= '0;
        level_q <= IDLE_LEVEL;
      end else begin
        cnt_q   <= (!mismatch || accept) ? '0 : cnt_q + 1'b1;
        level_q <= accept ? nxt : level_q;
      end
    assign level_o = level_q;
  end
  assign rise_o = accept & nxt;
  assign fall_o = accept & ~nxt;
endmodule

// File: rtl/key_pio_debounced.sv
// key_pio_debounced: debounced key PIO with edge capture and maskable IRQ.
// Define KEY_PIO_LONGPRESS_EN to add per-channel long-press status at address 6.
module key_pio_debounced
  import key_pio_pkg::*;
#(
  parameter int WIDTH            = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter bit IDLE_LEVEL       = 1'b1,
  parameter int LONGPRESS_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  key_pio_debounced_if.slave bus
);
  logic [WIDTH-1:0] raw, db, rise, fall, wdata, long_st;
  logic [WIDTH-1:0] rise_en_q, fall_en_q, mask_q, cap_q;
  logic [31:0] rd_d, rd_q;
  logic wr, unused_wd;
  assign wr        = bus.chipselect & ~bus.write_n;
  assign wdata     = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    key_debounce #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(IDLE_LEVEL)
    ) u_db (
      .clk(clk), .reset_n(reset_n), .d_i(in_port[g]),
      .sync_o(raw[g]), .level_o(db[g]), .rise_o(rise[g]), .fall_o(fall[g])
    );
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rise_en_q <= RISE_EN_RST[WIDTH-1:0];
      fall_en_q <= FALL_EN_RST[WIDTH-1:0];
      mask_q    <= IRQ_MASK_RST[WIDTH-1:0];
      cap_q     <= EDGE_CAP_RST[WIDTH-1:0];
      rd_q      <= '0;
    end else begin
      if (wr && bus.address == ADDR_RISE) rise_en_q <= wdata;
      if (wr && bus.address == ADDR_FALL) fall_en_q <= wdata;
      if (wr && bus.address == ADDR_MASK) mask_q <= wdata;
      // New events are OR'd in after the clear so a same-cycle set wins.
      cap_q <= (cap_q & ~((wr && bus.address == ADDR_CAP) ? wdata : '0))
             | (rise & rise_en_q) | (fall & fall_en_q);
      rd_q  <= rd_d;
    end
`ifdef KEY_PIO_LONGPRESS_EN
  localparam int LW = $clog2(LONGPRESS_CYCLES + 1);
  logic [WIDTH-1:0][LW-1:0] hold_q;
  logic [WIDTH-1:0] fired_q, long_q, hit;
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++)
      hit[i] = !db[i] && !fired_q[i] && (hold_q[i] == LW'(LONGPRESS_CYCLES - 1));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hold_q  <= '0;
      fired_q <= '0;
      long_q  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_q[i]  <= (db[i] || fired_q[i] || hit[i]) ? '0 : hold_q[i] + 1'b1;
        fired_q[i] <= !db[i] && (fired_q[i] || hit[i]);
      end
      long_q <= (long_q & ~((wr && bus.address == ADDR_LONG) ? wdata : '0)) | hit;
    end
  assign long_st = long_q;
`else
  localparam int unused_lp = LONGPRESS_CYCLES;
  assign long_st = '0;
`endif
  always_comb begin
    rd_d = '0;
    case (bus.address)
      ADDR_DATA: rd_d = 32'(db);
      ADDR_RISE: rd_d = 32'(rise_en_q);
      ADDR_MASK: rd_d = 32'(mask_q);
      ADDR_CAP:  rd_d = 32'(cap_q);
      ADDR_FALL: rd_d = 32'(fall_en_q);
      ADDR_RAW:  rd_d = 32'(raw);
      ADDR_LONG: rd_d = 32'(long_st);
      default:   rd_d = '0;
    endcase
  end
  assign bus.readdata = rd_q;
  assign bus.irq      = |((cap_q | long_st) & mask_q);
endmodule

// File: tb/tb_key_pio_debounced.sv
// tb_key_pio_debounced: directed checks of debounce, edge capture, W1C and irq (DEBOUNCE_CYCLES=4).
module tb_key_pio_debounced;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] in_port;
  int checks = 0;
  int errors = 0;
  key_pio_debounced_if bus ();
  key_pio_debounced #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .IDLE_LEVEL(1'b1), .LONGPRESS_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask
  logic [31:0] v;
  initial begin
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = '0;
    #1;
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_irq", {31'b0, bus.irq}, 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    rd(3'd0, v); chk("idle_data", v, 32'hF);
    rd(3'd3, v); chk("idle_cap", v, 32'h0);
    rd(3'd4, v); chk("rst_fall_en", v, 32'hF);
    rd(3'd1, v); chk("rst_rise_en", v, 32'h0);
    rd(3'd2, v); chk("rst_mask", v, 32'h0);
    chk("idle_irq", {31'b0, bus.irq}, 32'h0);
    // Key 0 press: debounced level must change on the 6th edge after the input change.
    bus.address = 3'd0;
    in_port = 4'hE;
    repeat (6) tick();
    chk("k0_data_before", bus.readdata, 32'hF);
    tick();
    chk("k0_data_after", bus.readdata, 32'hE);
    rd(3'd5, v); chk("k0_raw", v, 32'hE);
    rd(3'd3, v); chk("k0_cap", v, 32'h1);
    chk("k0_irq_masked", {31'b0, bus.irq}, 32'h0);
    wr(3'd2, 32'h1);
    chk("k0_irq_unmasked", {31'b0, bus.irq}, 32'h1);
    // Key 1 bounces every 3 cycles: never stable long enough to be accepted.
    bus.address = 3'd0;
    for (int i = 0; i < 10; i++) begin
      in_port[1] = ~in_port[1];
      repeat (3) tick();
      chk("bounce_data1", {31'b0, bus.readdata[1]}, 32'h1);
    end
    repeat (8) tick();
    rd(3'd0, v); chk("bounce_data", v, 32'hE);
    rd(3'd3, v); chk("bounce_cap", v, 32'h1);
    // Rising-edge only on key 2.
    wr(3'd3, 32'hF);
    wr(3'd1, 32'h4);
    wr(3'd4, 32'h0);
    in_port = 4'hA;
    repeat (8) tick();
    rd(3'd3, v); chk("k2_press_cap", v, 32'h0);
    rd(3'd0, v); chk("k2_press_data", v, 32'hA);
    in_port = 4'hE;
    repeat (8) tick();
    rd(3'd3, v); chk("k2_release_cap", v, 32'h4);
    // W1C behaviour and set-wins-over-clear.
    wr(3'd3, 32'hF);
    wr(3'd1, 32'h1);
    wr(3'd4, 32'h2);
    in_port = 4'hD;
    repeat (8) tick();
    rd(3'd3, v); chk("cap_both", v, 32'h3);
    chk("cap_both_irq", {31'b0, bus.irq}, 32'h1);
    wr(3'd3, 32'h1);
    rd(3'd3, v); chk("w1c_bit0", v, 32'h2);
    in_port = 4'hF;
    repeat (8) tick();
    rd(3'd3, v); chk("k1_release_cap", v, 32'h2);
    in_port = 4'hD;
    repeat (5) tick();
    wr(3'd3, 32'h2);
    rd(3'd3, v); chk("set_wins", v, 32'h2);
    wr(3'd3, 32'h2);
    rd(3'd3, v); chk("w1c_bit1", v, 32'h0);
    rd(3'd7, v); chk("addr7_zero", v, 32'h0);
`ifdef KEY_PIO_LONGPRESS_EN
    in_port = 4'hF;
    repeat (8) tick();
    wr(3'd6, 32'hF);
    rd(3'd6, v); chk("long_cleared", v, 32'h0);
    bus.address = 3'd6;
    in_port = 4'h7;
    repeat (22) tick();
    chk("long_before", bus.readdata, 32'h0);
    tick();
    chk("long_set", bus.readdata, 32'h8);
    repeat (2) tick();
    wr(3'd6, 32'h8);
    repeat (15) tick();
    chk("long_no_retrigger", bus.readdata, 32'h0);
`else
    rd(3'd6, v); chk("long_absent", v, 32'h0);
    wr(3'd6, 32'hF);
    rd(3'd6, v); chk("long_write_ignored", v, 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
